// File: rtl/tff_cnt_ctrl.sv
// Up/down sequencer for a WIDTH-bit T-flip-flop counter bank: clear, run to limit, pause/resume/abort.
// Define TFF_CNT_AUTO_RELOAD_EN to restart from CLEAR on every terminal match instead of returning to IDLE.
module tff_cnt_ctrl #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t,
    output logic             cnt_clr,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_PAUSE
    } state_t;

    state_t           state_q;
    logic             dir_q;
    logic [WIDTH-1:0] limit_q;
    logic             step_q;
    logic             cnt_clr_q;
    logic             done_q;

    logic [WIDTH-1:0] t_raw;
    logic             carry;
    logic             match;
    logic             issue;

    // Ripple-carry (up) or ripple-borrow (down) toggle pattern; bit 0 always toggles.
    always_comb begin
        t_raw = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_raw[i] = carry;
            carry    = carry & (dir_q ? ~q[i] : q[i]);
        end
    end

    // The step flag keeps a zero limit from matching before the first toggle.
    assign match = (state_q == ST_RUN) && step_q && (q == limit_q);
    assign issue = (state_q == ST_RUN) && !match && !stop;

    assign t       = issue ? t_raw : '0;
    assign busy    = (state_q != ST_IDLE);
    assign wrap    = busy && (t == {WIDTH{1'b1}});
    assign cnt_clr = cnt_clr_q;
    assign done    = done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= 1'b0;
            limit_q   <= '0;
            step_q    <= 1'b0;
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_q   <= ST_CLEAR;
                        dir_q     <= dir;
                        limit_q   <= limit;
                        cnt_clr_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    step_q  <= 1'b0;
                    state_q <= stop ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (match) begin
                        done_q <= 1'b1;
`ifdef TFF_CNT_AUTO_RELOAD_EN
                        state_q   <= ST_CLEAR;
                        cnt_clr_q <= 1'b1;
`else
                        state_q   <= ST_IDLE;
`endif
                    end else if (stop) begin
                        state_q <= ST_PAUSE;
                    end else begin
                        step_q <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (start) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tff_cnt_ctrl.sv
// Scoreboard bench for tff_cnt_ctrl (WIDTH=2) driving a behavioural T-FF counter bank.
module tb_tff_cnt_ctrl;

    localparam int W = 2;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         stop  = 1'b0;
    logic         dir   = 1'b0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] q     = '0;
    logic [W-1:0] t;
    logic         cnt_clr;
    logic         busy;
    logic         wrap;
    logic         done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] t;
        logic         clr;
        logic         busy;
        logic         wrap;
        logic         done;
        logic [W-1:0] q;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    tff_cnt_ctrl #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .dir     (dir),
        .limit   (limit),
        .q       (q),
        .t       (t),
        .cnt_clr (cnt_clr),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done)
    );

    always #5 clock = ~clock;

    // Counter bank: shares the system reset, synchronous clear, toggles per t.
    always @(posedge clock) begin
        if (reset)        q <= '0;
        else if (cnt_clr) q <= '0;
        else              q <= q ^ t;
    end

    // Monitor: one expected record per presented cycle, compared mid-cycle.
    always @(negedge clock) begin
        exp_t  e;
        exp_t  a;
        string tg;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tg = tag_q.pop_front();
            a = '{t: t, clr: cnt_clr, busy: busy, wrap: wrap, done: done, q: q};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got t=%b clr=%b busy=%b wrap=%b done=%b q=%b, want t=%b clr=%b busy=%b wrap=%b done=%b q=%b",
                         tg, a.t, a.clr, a.busy, a.wrap, a.done, a.q,
                         e.t, e.clr, e.busy, e.wrap, e.done, e.q);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic cy(input logic rs, input logic st, input logic sp,
                      input logic [W-1:0] et, input logic ec, input logic eb,
                      input logic ew, input logic ed, input logic [W-1:0] eq,
                      input string tg);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rs;
        start = st;
        stop  = sp;
        e = '{t: et, clr: ec, busy: eb, wrap: ew, done: ed, q: eq};
        exp_q.push_back(e);
        tag_q.push_back(tg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, want end before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock);
        //  rs st sp  t      clr busy wrap done q
        cy(1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, "reset_hold");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, "reset_idle");

        // up count, limit 3
        dir = 1'b0; limit = 2'd3;
        cy(0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, "up_start");
        cy(0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, "up_clear");
        cy(0, 0, 0, 2'b01, 0, 1, 0, 0, 2'b00, "up_q0");
        cy(0, 1, 0, 2'b11, 0, 1, 1, 0, 2'b01, "up_q1_start_ignored");
        cy(0, 0, 0, 2'b01, 0, 1, 0, 0, 2'b10, "up_q2");
        cy(0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b11, "up_match");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b11, "up_done");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b11, "up_after");

        // full cycle, limit 0
        dir = 1'b0; limit = 2'd0;
        cy(0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b11, "full_start");
        cy(0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b11, "full_clear");
        cy(0, 0, 0, 2'b01, 0, 1, 0, 0, 2'b00, "full_q0_no_match");
        cy(0, 0, 0, 2'b11, 0, 1, 1, 0, 2'b01, "full_q1");
        cy(0, 0, 0, 2'b01, 0, 1, 0, 0, 2'b10, "full_q2");
        cy(0, 0, 0, 2'b11, 0, 1, 1, 0, 2'b11, "full_q3_wrap");
        cy(0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b00, "full_match");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, "full_done");

        // down count, limit 1
        dir = 1'b1; limit = 2'd1;
        cy(0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, "dn_start");
        cy(0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, "dn_clear");
        cy(0, 0, 0, 2'b11, 0, 1, 1, 0, 2'b00, "dn_q0_wrap");
        cy(0, 0, 0, 2'b01, 0, 1, 0, 0, 2'b11, "dn_q3");
        cy(0, 0, 0, 2'b11, 0, 1, 1, 0, 2'b10, "dn_q2");
        cy(0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b01, "dn_match");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b01, "dn_done");

        // pause and resume
        dir = 1'b0; limit = 2'd3;
        cy(0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b01, "pr_start");
        cy(0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b01, "pr_clear");
        cy(0, 0, 0, 2'b01, 0, 1, 0, 0, 2'b00, "pr_q0");
        cy(0, 0, 1, 2'b00, 0, 1, 0, 0, 2'b01, "pr_stop_q1");
        for (int i = 0; i < 5; i++)
            cy(0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b01, "pr_hold");
        cy(0, 1, 0, 2'b00, 0, 1, 0, 0, 2'b01, "pr_resume");
        cy(0, 0, 0, 2'b11, 0, 1, 1, 0, 2'b01, "pr_q1");
        cy(0, 0, 0, 2'b01, 0, 1, 0, 0, 2'b10, "pr_q2");
        cy(0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b11, "pr_match");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b11, "pr_done");

        // pause then abort
        cy(0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b11, "ab_start");
        cy(0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b11, "ab_clear");
        cy(0, 0, 0, 2'b01, 0, 1, 0, 0, 2'b00, "ab_q0");
        cy(0, 0, 1, 2'b00, 0, 1, 0, 0, 2'b01, "ab_stop_q1");
        cy(0, 1, 1, 2'b00, 0, 1, 0, 0, 2'b01, "ab_abort_stop_wins");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, "ab_idle_no_done");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, "ab_idle2");

        // start with stop in IDLE, stop in CLEAR
        cy(0, 1, 1, 2'b00, 0, 0, 0, 0, 2'b01, "idle_startstop");
        cy(0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b01, "idle_stays");
        cy(0, 0, 1, 2'b00, 1, 1, 0, 0, 2'b01, "clear_stop");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, "clear_abort_idle");

        // reset mid-run at q=2
        cy(0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, "rr_start");
        cy(0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, "rr_clear");
        cy(0, 0, 0, 2'b01, 0, 1, 0, 0, 2'b00, "rr_q0");
        cy(0, 0, 0, 2'b11, 0, 1, 1, 0, 2'b01, "rr_q1");
        cy(1, 0, 0, 2'b01, 0, 1, 0, 0, 2'b10, "rr_q2_reset");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, "rr_idle");

`ifdef TFF_CNT_AUTO_RELOAD_EN
        // auto reload, limit 2: clear + three run cycles per pass
        dir = 1'b0; limit = 2'd2;
        cy(0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, "ar_start");
        cy(0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, "ar_clear");
        for (int p = 0; p < 2; p++) begin
            cy(0, 0, 0, 2'b01, 0, 1, 0, 0, 2'b00, "ar_q0");
            cy(0, 0, 0, 2'b11, 0, 1, 1, 0, 2'b01, "ar_q1");
            cy(0, 0, 0, 2'b00, 0, 1, 0, 0, 2'b10, "ar_match");
            cy(0, 0, 0, 2'b00, 1, 1, 0, 1, 2'b10, "ar_reclear_done");
        end
        cy(0, 0, 1, 2'b00, 0, 1, 0, 0, 2'b00, "ar_stop");
        cy(0, 0, 1, 2'b00, 0, 1, 0, 0, 2'b00, "ar_pause_abort");
        cy(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, "ar_idle");
`endif

        repeat (3) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
